// File: rtl/frame_timer_pkg.sv
// Shared types and defaults for the frame-based timer bank.
package frame_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

    localparam int DEFAULT_CNT_W = 11;

endpackage

// File: rtl/frame_timer_channel.sv
// One countdown channel: load, per-frame decrement, one-clock expiry pulse,
// optional auto-reload. Cancel beats start, start beats expiry/decrement.
module frame_timer_channel
    import frame_timer_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic             pause,
    input  logic             i_start,
    input  logic             i_cancel,
    input  logic [CNT_W-1:0] i_time,
    input  logic             i_periodic,
    output logic             o_fire,
    output logic             o_expired,
    output logic             o_active,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    timer_state_t     r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_reload;
    logic             r_periodic;
    logic             r_expired;
    logic             w_fire;

    // Expiry happens on the edge after count reaches 0, unless overridden.
    assign w_fire = (r_state == RUN) && (r_count == '0) && !i_cancel && !i_start;

    // Channel FSM with count, reload and mode registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_reload   <= '0;
            r_periodic <= 1'b0;
            r_expired  <= 1'b0;
        end else begin
            r_expired <= w_fire;
            if (i_cancel) begin
                r_state <= IDLE;
                r_count <= '0;
            end else if (i_start) begin
                r_state    <= RUN;
                r_count    <= i_time;
                r_reload   <= i_time;
                r_periodic <= i_periodic;
            end else if (r_state == RUN) begin
                if (r_count == '0) begin
                    // A zero reload would spin forever, so it degrades to one-shot.
                    if (r_periodic && (r_reload != '0)) begin
                        r_count <= r_reload;
                    end else begin
                        r_state <= IDLE;
                    end
                end else if (startOfFrame && !pause) begin
                    r_count <= r_count - CNT_ONE;
                end
            end
        end
    end

    assign o_fire    = w_fire;
    assign o_expired = r_expired;
    assign o_active  = (r_state == RUN);
    assign o_count   = r_count;

endmodule

// File: rtl/frame_timer_bank.sv
// Bank of NUM_CH independent frame countdown timers with a shared request port.
module frame_timer_bank
    import frame_timer_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = DEFAULT_CNT_W,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    pause,
    input  logic                    req_valid,
    input  logic [CH_W-1:0]         req_ch,
    input  logic [CNT_W-1:0]        req_time,
    input  logic                    req_periodic,
    input  logic [NUM_CH-1:0]       cancel,
    output logic [NUM_CH-1:0]       expired,
    output logic [NUM_CH-1:0]       active,
    output logic                    any_expired,
    output logic [NUM_CH*CNT_W-1:0] remaining
);

    logic [NUM_CH-1:0] w_start;
    logic [NUM_CH-1:0] w_fire;
    logic              r_any_expired;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // Out-of-range channel numbers match no decoder and are dropped.
        assign w_start[g] = req_valid && (int'(req_ch) == g);

        frame_timer_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk          (clk),
            .resetN       (resetN),
            .startOfFrame (startOfFrame),
            .pause        (pause),
            .i_start      (w_start[g]),
            .i_cancel     (cancel[g]),
            .i_time       (req_time),
            .i_periodic   (req_periodic),
            .o_fire       (w_fire[g]),
            .o_expired    (expired[g]),
            .o_active     (active[g]),
            .o_count      (remaining[g*CNT_W +: CNT_W])
        );
    end

    // Registered OR of the channels' next-cycle expiry, aligned with expired.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_any_expired <= 1'b0;
        end else begin
            r_any_expired <= |w_fire;
        end
    end

    assign any_expired = r_any_expired;

endmodule
